cache_assoc_wb: RTL
===================

# cache_assoc_wb

Parametrised fully-associative, write-back, write-allocate cache with true-LRU replacement. It sits between a CPU-side request port and the main-memory RAM. The fixed delays of the previous generation are replaced by a ready/valid request port and a req/ack memory handshake. This generation adds reset, a parametrised line count and widths, an explicit victim-selection rule, and a flush operation that writes back all dirty lines.

## Interface
- LINES, 4, number of cache lines (power of two, ≥2); one data word per line
- ADDR_W, 5, address width; the full address is the tag
- DATA_W, 8, data word width
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  cache accepts a request (high only in IDLE)
- req_wren  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  one-cycle pulse: request complete
- resp_rdata  out  DATA_W  read data; valid with resp_valid on reads
- resp_hit  out  1  with resp_valid: 1 = hit, 0 = miss
- flush  in  1  sampled in IDLE only; starts a write-back of all dirty lines
- flush_done  out  1  one-cycle pulse when the flush completes
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write-back, 0 = fill read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write-back data
- mem_ack  in  1  memory completes the transaction this cycle
- mem_rdata  in  DATA_W  fill data; valid in the mem_ack cycle

## Operation
- Per-line state: valid, dirty, tag[ADDR_W], data[DATA_W], age[clog2(LINES)].
- Reset state:
  - valid = 0 and dirty = 0 for every line.
  - age[i] = i.
  - FSM in IDLE.
  - All outputs 0, except req_ready = 1.
- Ages always form a permutation of 0..LINES-1.
- Lookup: a line hits when valid is 1 and tag == req_addr. At most one line can hit.
- Victim selection, evaluated at accept time:
  - the lowest-index invalid line, if any;
  - otherwise the line with age == LINES-1.
- LRU update on every completed access to line k (hit or install): each line with age < age[k] increments; age[k] becomes 0. Flush does not touch ages.
- FSM states: IDLE, WB, FILL, RESP, FLUSH.
- IDLE, accepting a request (req_valid & req_ready):
  - Read hit: latch the data; go to RESP.
  - Write hit: data ← req_wdata, dirty ← 1; go to RESP.
  - Miss, victim valid and dirty: go to WB.
  - Miss, otherwise: a read goes to FILL; a write installs the line directly (tag, data = req_wdata, valid = 1, dirty = 1) and goes to RESP. No fill is done on a write miss.
- WB: mem_req = 1, mem_we = 1, mem_addr = victim tag, mem_wdata = victim data. On mem_ack:
  - victim dirty ← 0;
  - a read then goes to FILL;
  - a write installs the line as above and goes to RESP.
- FILL: mem_req = 1, mem_we = 0, mem_addr = request address. On mem_ack: install tag, data = mem_rdata, valid = 1, dirty = 0; go to RESP.
- RESP: resp_valid = 1 and resp_hit is driven. Next state is IDLE.
- flush in IDLE has priority over req_valid. req_ready is 0 in that cycle.
- FLUSH: scans lines 0..LINES-1 in order. Each valid and dirty line is written back with the WB handshake and then has dirty ← 0. Clean or invalid lines cost one cycle each. After the last line, flush_done pulses for one cycle, valid is unchanged, and the FSM returns to IDLE.
- The request address and write data are latched at accept. CPU inputs are ignored outside IDLE.

## Timing
- Hit: accepted at cycle T; resp_valid at T+1; req_ready high again at T+2.
- Clean read miss: mem_req rises at T+1. If mem_ack arrives at cycle A, resp_valid is at A+1.
- Write miss into a clean or invalid victim: resp_valid at T+1, with resp_hit = 0.
- Dirty-victim miss: the write-back and the fill are back-to-back. mem_req stays high across the WB→FILL change. mem_we and mem_addr change in the cycle after the write-back ack.
- mem_req, mem_we, mem_addr and mem_wdata are registered and hold stable until mem_ack.
  - mem_ack is honoured only while mem_req = 1; otherwise it is ignored.
  - mem_ack may arrive in the first cycle of mem_req.
- Reset in any state returns to the reset state in the next cycle and drops mem_req. An in-flight memory transaction is abandoned, and the memory side must tolerate this.

## Test plan
- Reset, then read 0x03 with mem_rdata = 0x5A and ack after 2 cycles.
  - Required: mem_req with addr 0x03 and we = 0; resp_rdata = 0x5A with resp_hit = 0.
  - Reading 0x03 again: resp_hit = 1 one cycle after accept, with no mem_req.
- Write 0x11 = 0xAA, then read 0x11.
  - Required: the write responds at T+1 with no memory traffic (write allocate, no fill); the read hits and returns 0xAA.
- Fill 4 lines with addresses 0..3, access address 0 again, then read 0x08.
  - Required: line 1 (the LRU line) is evicted; reading address 1 then misses and address 0 hits.
- Dirty eviction: write 0..3 with values 0x10..0x13, then read 0x1F.
  - Required: mem write of addr 0x00 / data 0x10 first, then a mem read of 0x1F, then resp_valid.
- Flush with lines 1 and 3 dirty.
  - Required: exactly two mem writes (line 1, then line 3); flush_done pulses once.
  - After the flush, every line is clean and still valid; a re-read hits.
- Assert reset while in FILL, with mem_ack withheld.
  - Required: mem_req = 0 and req_ready = 1 on the next cycle; every subsequent access misses.

Source files
------------

// File: rtl/cache_assoc_wb.sv
// Fully-associative write-back, write-allocate cache with true-LRU replacement,
// a ready/valid CPU port, a req/ack memory port and a flush of all dirty lines.
module cache_assoc_wb #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wren,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  input  logic              flush,
  output logic              flush_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IDX_W = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WB    = 3'd1,
    ST_FILL  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FLUSH = 3'd4
  } state_t;

  state_t state_r, state_nx;

  logic [LINES-1:0]  valid_r, dirty_r;
  logic [ADDR_W-1:0] tag_r  [LINES];
  logic [DATA_W-1:0] data_r [LINES];
  logic [IDX_W-1:0]  age_r  [LINES];

  logic              wren_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [IDX_W-1:0]  victim_r, flush_idx_r;

  logic              ready_r, resp_valid_r, resp_hit_r, flush_done_r;
  logic [DATA_W-1:0] resp_rdata_r;
  logic              mem_req_r, mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;

  logic              hit_s, inv_found_s, ack_s, accept_s, flush_wb_s;
  logic [IDX_W-1:0]  hit_idx_s, inv_idx_s, old_idx_s, victim_s;
  logic [IDX_W-1:0]  victim_nx_s, flush_idx_nx;
  logic [ADDR_W-1:0] addr_nx_s;

  logic              hit_wr_s, install_s, install_dirty_s, clear_s, touch_s;
  logic [IDX_W-1:0]  install_idx_s, clear_idx_s, touch_idx_s;
  logic [ADDR_W-1:0] install_tag_s;
  logic [DATA_W-1:0] install_data_s, resp_rdata_nx;
  logic              resp_hit_nx, flush_done_nx;

  logic              mem_req_nx, mem_we_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [DATA_W-1:0] mem_wdata_nx;

  // A request can only be taken in IDLE and never in the cycle a flush is sampled.
  assign req_ready  = ready_r & ~flush;
  assign ack_s      = mem_ack & mem_req_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_hit   = resp_hit_r;
  assign flush_done = flush_done_r;
  assign mem_req    = mem_req_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;

  // Tag lookup and victim choice; descending scan leaves the lowest invalid index.
  always_comb begin
    hit_s       = 1'b0;
    hit_idx_s   = {IDX_W{1'b0}};
    inv_found_s = 1'b0;
    inv_idx_s   = {IDX_W{1'b0}};
    old_idx_s   = {IDX_W{1'b0}};
    for (int i = LINES - 1; i >= 0; i--) begin
      hit_idx_s   = (valid_r[i] && tag_r[i] == req_addr) ? IDX_W'(i) : hit_idx_s;
      hit_s       = hit_s | (valid_r[i] && tag_r[i] == req_addr);
      inv_idx_s   = (!valid_r[i]) ? IDX_W'(i) : inv_idx_s;
      inv_found_s = inv_found_s | !valid_r[i];
      old_idx_s   = (age_r[i] == AGE_MAX) ? IDX_W'(i) : old_idx_s;
    end
    victim_s = inv_found_s ? inv_idx_s : old_idx_s;
  end

  // Next-state logic and the array update strobes it implies.
  always_comb begin
    state_nx        = state_r;
    accept_s        = 1'b0;
    hit_wr_s        = 1'b0;
    install_s       = 1'b0;
    install_idx_s   = victim_r;
    install_tag_s   = addr_r;
    install_data_s  = wdata_r;
    install_dirty_s = 1'b0;
    clear_s         = 1'b0;
    clear_idx_s     = victim_r;
    touch_s         = 1'b0;
    touch_idx_s     = victim_r;
    flush_idx_nx    = flush_idx_r;
    flush_done_nx   = 1'b0;
    resp_hit_nx     = 1'b0;
    resp_rdata_nx   = {DATA_W{1'b0}};
    flush_wb_s      = valid_r[flush_idx_r] & dirty_r[flush_idx_r];
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          state_nx     = ST_FLUSH;
          flush_idx_nx = {IDX_W{1'b0}};
        end else if (req_valid && req_ready) begin
          accept_s = 1'b1;
          if (hit_s) begin
            touch_s     = 1'b1;
            touch_idx_s = hit_idx_s;
            resp_hit_nx = 1'b1;
            state_nx    = ST_RESP;
            if (req_wren) begin
              hit_wr_s = 1'b1;
            end else begin
              resp_rdata_nx = data_r[hit_idx_s];
            end
          end else if (valid_r[victim_s] && dirty_r[victim_s]) begin
            state_nx = ST_WB;
          end else if (req_wren) begin
            install_s       = 1'b1;
            install_idx_s   = victim_s;
            install_tag_s   = req_addr;
            install_data_s  = req_wdata;
            install_dirty_s = 1'b1;
            touch_s         = 1'b1;
            touch_idx_s     = victim_s;
            state_nx        = ST_RESP;
          end else begin
            state_nx = ST_FILL;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WB: begin
        if (ack_s) begin
          clear_s = 1'b1;
          if (wren_r) begin
            install_s       = 1'b1;
            install_dirty_s = 1'b1;
            touch_s         = 1'b1;
            state_nx        = ST_RESP;
          end else begin
            state_nx = ST_FILL;
          end
        end else begin
          state_nx = ST_WB;
        end
      end
      ST_FILL: begin
        if (ack_s) begin
          install_s      = 1'b1;
          install_data_s = mem_rdata;
          touch_s        = 1'b1;
          resp_rdata_nx  = mem_rdata;
          state_nx       = ST_RESP;
        end else begin
          state_nx = ST_FILL;
        end
      end
      ST_RESP: begin
        state_nx = ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_wb_s && !ack_s) begin
          state_nx = ST_FLUSH;
        end else begin
          clear_s     = flush_wb_s;
          clear_idx_s = flush_idx_r;
          if (flush_idx_r == AGE_MAX) begin
            state_nx      = ST_IDLE;
            flush_done_nx = 1'b1;
          end else begin
            flush_idx_nx = flush_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Memory-port values for the coming cycle, looked up with the next-cycle indices.
  always_comb begin
    victim_nx_s  = accept_s ? victim_s : victim_r;
    addr_nx_s    = accept_s ? req_addr : addr_r;
    mem_req_nx   = 1'b0;
    mem_we_nx    = 1'b0;
    mem_addr_nx  = {ADDR_W{1'b0}};
    mem_wdata_nx = {DATA_W{1'b0}};
    case (state_nx)
      ST_WB: begin
        mem_req_nx   = 1'b1;
        mem_we_nx    = 1'b1;
        mem_addr_nx  = tag_r[victim_nx_s];
        mem_wdata_nx = data_r[victim_nx_s];
      end
      ST_FILL: begin
        mem_req_nx  = 1'b1;
        mem_addr_nx = addr_nx_s;
      end
      ST_FLUSH: begin
        if (valid_r[flush_idx_nx] && dirty_r[flush_idx_nx]) begin
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b1;
          mem_addr_nx  = tag_r[flush_idx_nx];
          mem_wdata_nx = data_r[flush_idx_nx];
        end else begin
          mem_req_nx = 1'b0;
        end
      end
      default: begin
        mem_req_nx = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Registered outputs and request latches.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      flush_done_r <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      mem_wdata_r  <= {DATA_W{1'b0}};
      wren_r       <= 1'b0;
      addr_r       <= {ADDR_W{1'b0}};
      wdata_r      <= {DATA_W{1'b0}};
      victim_r     <= {IDX_W{1'b0}};
      flush_idx_r  <= {IDX_W{1'b0}};
    end else begin
      ready_r      <= (state_nx == ST_IDLE);
      resp_valid_r <= (state_nx == ST_RESP);
      resp_hit_r   <= resp_hit_nx;
      resp_rdata_r <= resp_rdata_nx;
      flush_done_r <= flush_done_nx;
      mem_req_r    <= mem_req_nx;
      mem_we_r     <= mem_we_nx;
      mem_addr_r   <= mem_addr_nx;
      mem_wdata_r  <= mem_wdata_nx;
      victim_r     <= victim_nx_s;
      addr_r       <= addr_nx_s;
      flush_idx_r  <= flush_idx_nx;
      if (accept_s) begin
        wren_r  <= req_wren;
        wdata_r <= req_wdata;
      end
    end
  end

  // Line arrays and LRU ages; an install after a write-back re-dirties the same line.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
      for (int i = 0; i < LINES; i++) begin
        tag_r[i]  <= {ADDR_W{1'b0}};
        data_r[i] <= {DATA_W{1'b0}};
        age_r[i]  <= IDX_W'(i);
      end
    end else begin
      if (hit_wr_s) begin
        data_r[hit_idx_s]  <= req_wdata;
        dirty_r[hit_idx_s] <= 1'b1;
      end
      if (clear_s) begin
        dirty_r[clear_idx_s] <= 1'b0;
      end
      if (install_s) begin
        tag_r[install_idx_s]   <= install_tag_s;
        data_r[install_idx_s]  <= install_data_s;
        valid_r[install_idx_s] <= 1'b1;
        dirty_r[install_idx_s] <= install_dirty_s;
      end
      if (touch_s) begin
        for (int j = 0; j < LINES; j++) begin
          if (IDX_W'(j) == touch_idx_s) begin
            age_r[j] <= {IDX_W{1'b0}};
          end else if (age_r[j] < age_r[touch_idx_s]) begin
            age_r[j] <= age_r[j] + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end
      end
    end
  end

endmodule
